karatsuba_serial_scheduler: RTL and testbench
=============================================

Name: karatsuba_serial_scheduler

Overview:
Sequencer for a 2-way Karatsuba GF(2)[x] multiplier that shares ONE digit-serial shift-XOR multiply core across the three half-size sub-products: lo*lo, hi*hi, and (lo^hi)*(lo^hi).
It accepts operands via a ready/valid start handshake and schedules the three passes back-to-back with fixed latency.
It then combines the partial products and holds the result until the consumer accepts it.
It sits between the ECC field-arithmetic control and the large-multiplier datapath, replacing three parallel serial units with one.

Parameters:
WIDTH, 233, operand width in bits
DIGIT, 1, operand bits consumed per core cycle (must divide HALF or pad; 1, 2, 4 supported)
HALF, (WIDTH+1)/2 = 117, low-half width; high half is WIDTH-HALF = 116 bits
NPASS, ceil(HALF/DIGIT) = 117, cycles per sub-product pass

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
a  in  WIDTH  multiplicand, sampled on start accept
b  in  WIDTH  multiplier, sampled on start accept
start  in  1  request valid
ready  out  1  high only in IDLE; start accepted when start&&ready at posedge
c  out  2*WIDTH  GF(2) product, bit 2*WIDTH-1 always 0
c_valid  out  1  result valid, held until c_ready
c_ready  in  1  consumer accepts result
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, any state, including mid-pass): state=IDLE, c=0, c_valid=0, busy=0, ready=1, all accumulators/counters/operand registers=0. Release proceeds normally on the next edge.
- Splits: a_lo=a[HALF-1:0], a_hi=a[WIDTH-1:HALF] zero-extended to HALF bits; same for b. Mid operands are a_m=a_lo^a_hi, b_m=b_lo^b_hi.
- FSM states: IDLE -> MUL_LL -> MUL_HH -> MUL_MID -> COMBINE -> DONE -> IDLE.
  - IDLE: on start&&ready, latch a and b, clear core accumulator and digit counter, go to MUL_LL.
  - MUL_x: each cycle the core processes digit k (bits k*DIGIT..k*DIGIT+DIGIT-1) of the first operand: acc ^= second_operand·digit << (k*DIGIT). Counter runs 0..NPASS-1.
  - Pass end (counter==NPASS-1): store acc into p_ll, p_hh or p_mid (2*HALF-1 bits), clear acc and counter, advance state. No idle cycle between passes.
  - COMBINE (1 cycle): c <= p_ll ^ ((p_mid^p_ll^p_hh) << HALF) ^ (p_hh << 2*HALF), truncated to 2*WIDTH bits; c_valid <= 1 at the same edge; go to DONE.
  - DONE: c and c_valid held stable while c_ready=0. On c_valid&&c_ready: c_valid<=0, go to IDLE; c keeps its last value.
- Fixed latency, no zero-digit skipping: with the accept at edge 0, c_valid rises after edge 3*NPASS+1 (352 for defaults, DIGIT=1).
- Throughput: one multiply per 3*NPASS+3 cycles minimum. ready is 0 from accept through DONE, so start is ignored while busy.
- A start asserted in the same cycle as the DONE handshake is not accepted; it is accepted in the following IDLE cycle.
- All arithmetic is carry-free (XOR). Karatsuba subtraction is XOR.

Decomposition:
- Package karatsuba_pkg: WIDTH/HALF/DIGIT defaults, NPASS function (ceil div), state enum {IDLE, MUL_LL, MUL_HH, MUL_MID, COMBINE, DONE}, product-width constant 2*HALF-1.
- Sub-module gf2_digit_serial_mac: HALF x HALF digit-serial shift-XOR unit with ports clear, step, digit index, operands and acc out. The scheduler instantiates it once and muxes operands per state.

Test Plan:
- Basic: a=3, b=3, c_ready=1 -> c=5 ((x+1)^2 = x^2+1); c_valid after exactly 352 cycles; ready=0 throughout.
- Split boundary: a=(1<<116)|(1<<117), b=1 -> c=a. a=1<<117, b=1<<117 -> c=1<<234 (hh path). a=1<<232, b=1<<232 -> c=1<<464, c[465]=0.
- Backpressure: c_ready=0 for 50 cycles after c_valid -> c and c_valid stable and start ignored; c_ready=1 -> c_valid drops next edge and ready=1.
- Reset mid-op: rst pulsed asynchronously (between edges) during MUL_HH -> outputs zero immediately. A new request a=3, b=5 -> c=15, latency 352.
- Back-to-back: 200 random (a,b) pairs with c_ready=1 and start held high -> every c matches a bit-serial golden GF(2) multiply; accepts spaced exactly 354 cycles apart.
- Ignored start: start pulsed during MUL_MID with different operands -> result of the original request unchanged; no second result produced.

Source files
------------

// File: rtl/karatsuba_pkg.sv
// rtl/karatsuba_pkg.sv - shared defaults, sizing helpers and state encoding for the Karatsuba scheduler
package karatsuba_pkg;

  localparam int K_WIDTH = 233;
  localparam int K_DIGIT = 1;

  // Low half takes the extra bit when WIDTH is odd
  function automatic int half_of(input int width);
    return (width + 1) / 2;
  endfunction

  // Core cycles per sub-product; a ragged last digit is zero-padded
  function automatic int npass_of(input int half, input int digit);
    return (half + digit - 1) / digit;
  endfunction

  // Width of a HALF x HALF carry-free product
  function automatic int prod_w_of(input int half);
    return 2 * half - 1;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    MUL_LL,
    MUL_HH,
    MUL_MID,
    COMBINE,
    DONE
  } state_t;

endpackage

// File: rtl/gf2_digit_serial_mac.sv
// rtl/gf2_digit_serial_mac.sv - HALF x HALF digit-serial shift-XOR GF(2)[x] multiply core
module gf2_digit_serial_mac
  import karatsuba_pkg::*;
#(
  parameter int HALF  = 117,
  parameter int DIGIT = 1,
  parameter int NPASS = npass_of(HALF, DIGIT),
  parameter int IDX_W = (NPASS > 1) ? $clog2(NPASS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  step,
  input  logic [IDX_W-1:0]      digit_idx,
  input  logic [HALF-1:0]       op_a,
  input  logic [HALF-1:0]       op_b,
  output logic [2*HALF-2:0]     acc_next
);

  localparam int PW    = prod_w_of(HALF);
  localparam int PAD_W = NPASS * DIGIT;

  logic [PW-1:0]    r_acc;
  logic [PAD_W-1:0] w_a_pad;
  logic [DIGIT-1:0] w_digit;
  int               w_base;

  assign w_a_pad = PAD_W'(op_a);
  assign w_base  = int'(digit_idx) * DIGIT;
  assign w_digit = DIGIT'(w_a_pad >> w_base);

  // Accumulator value after folding in the current digit; exposed so the
  // scheduler can capture the finished product on the last step itself
  always_comb begin
    acc_next = r_acc;
    for (int j = 0; j < DIGIT; j++) begin
      if (w_digit[j]) acc_next = acc_next ^ (PW'(op_b) << (w_base + j));
    end
  end

  // Accumulator register; clear wins so a pass end can restart the core
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_acc <= '0;
    else if (clear) r_acc <= '0;
    else if (step)  r_acc <= acc_next;
  end

endmodule

// File: rtl/karatsuba_serial_scheduler.sv
// rtl/karatsuba_serial_scheduler.sv - schedules three Karatsuba sub-products through one serial core
module karatsuba_serial_scheduler
  import karatsuba_pkg::*;
#(
  parameter int WIDTH = K_WIDTH,
  parameter int DIGIT = K_DIGIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 start,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   c,
  output logic                 c_valid,
  input  logic                 c_ready,
  output logic                 busy
);

  localparam int HALF  = half_of(WIDTH);
  localparam int NPASS = npass_of(HALF, DIGIT);
  localparam int PW    = prod_w_of(HALF);
  localparam int CW    = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam int OW    = 2 * WIDTH;

  state_t          r_state;
  state_t          w_state_nx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_p_ll;
  logic [PW-1:0]   r_p_hh;
  logic [PW-1:0]   r_p_mid;
  logic [OW-1:0]   r_c;
  logic            r_c_valid;

  logic            w_ready;
  logic            w_accept;
  logic            w_in_mul;
  logic            w_cnt_last;
  logic            w_pass_end;
  logic            w_mac_clear;
  logic [HALF-1:0] w_a_lo;
  logic [HALF-1:0] w_a_hi;
  logic [HALF-1:0] w_b_lo;
  logic [HALF-1:0] w_b_hi;
  logic [HALF-1:0] w_op_a;
  logic [HALF-1:0] w_op_b;
  logic [PW-1:0]   w_acc_next;
  logic [PW-1:0]   w_p_cross;
  logic [OW-1:0]   w_c_comb;

  assign w_a_lo = r_a[HALF-1:0];
  assign w_a_hi = HALF'(r_a[WIDTH-1:HALF]);
  assign w_b_lo = r_b[HALF-1:0];
  assign w_b_hi = HALF'(r_b[WIDTH-1:HALF]);

  assign w_cnt_last  = (r_cnt == CW'(NPASS - 1));
  assign w_mac_clear = w_accept | w_pass_end;

  // Karatsuba recombination: the middle term is p_mid minus both outer
  // products, which in GF(2) is plain XOR
  assign w_p_cross = r_p_mid ^ r_p_ll ^ r_p_hh;
  assign w_c_comb  = OW'(r_p_ll) ^ (OW'(w_p_cross) << HALF) ^ (OW'(r_p_hh) << (2 * HALF));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // Next state, handshake and core operand selection per pass
  always_comb begin
    w_state_nx = r_state;
    w_ready    = 1'b0;
    w_accept   = 1'b0;
    w_in_mul   = 1'b0;
    w_pass_end = 1'b0;
    w_op_a     = '0;
    w_op_b     = '0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = MUL_LL;
        end
      end
      MUL_LL: begin
        w_in_mul = 1'b1;
        w_op_a   = w_a_lo;
        w_op_b   = w_b_lo;
        if (w_cnt_last) begin
          w_pass_end = 1'b1;
          w_state_nx = MUL_HH;
        end
      end
      MUL_HH: begin
        w_in_mul = 1'b1;
        w_op_a   = w_a_hi;
        w_op_b   = w_b_hi;
        if (w_cnt_last) begin
          w_pass_end = 1'b1;
          w_state_nx = MUL_MID;
        end
      end
      MUL_MID: begin
        w_in_mul = 1'b1;
        w_op_a   = w_a_lo ^ w_a_hi;
        w_op_b   = w_b_lo ^ w_b_hi;
        if (w_cnt_last) begin
          w_pass_end = 1'b1;
          w_state_nx = COMBINE;
        end
      end
      COMBINE: w_state_nx = DONE;
      DONE: begin
        if (r_c_valid && c_ready) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Operand capture on start accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  // Digit counter, restarted at accept and at every pass boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_cnt <= '0;
    else if (w_mac_clear) r_cnt <= '0;
    else if (w_in_mul)    r_cnt <= r_cnt + CW'(1);
  end

  // Partial product capture at the end of each pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_ll  <= '0;
      r_p_hh  <= '0;
      r_p_mid <= '0;
    end else if (w_pass_end) begin
      case (r_state)
        MUL_LL:  r_p_ll  <= w_acc_next;
        MUL_HH:  r_p_hh  <= w_acc_next;
        MUL_MID: r_p_mid <= w_acc_next;
        default: ;
      endcase
    end
  end

  // Result register; c keeps its last value after the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c       <= '0;
      r_c_valid <= 1'b0;
    end else if (r_state == COMBINE) begin
      r_c       <= w_c_comb;
      r_c_valid <= 1'b1;
    end else if (r_c_valid && c_ready) begin
      r_c_valid <= 1'b0;
    end
  end

  gf2_digit_serial_mac #(
    .HALF  (HALF),
    .DIGIT (DIGIT),
    .NPASS (NPASS),
    .IDX_W (CW)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_mac_clear),
    .step      (w_in_mul),
    .digit_idx (r_cnt),
    .op_a      (w_op_a),
    .op_b      (w_op_b),
    .acc_next  (w_acc_next)
  );

  assign ready   = w_ready;
  assign busy    = ~w_ready;
  assign c       = r_c;
  assign c_valid = r_c_valid;

endmodule

// File: tb/tb_karatsuba_serial_scheduler.sv
// tb/tb_karatsuba_serial_scheduler.sv - self-checking bench for karatsuba_serial_scheduler
module tb_karatsuba_serial_scheduler;

  localparam int W   = 233;
  localparam int OW  = 2 * W;
  localparam int LAT = 352;
  localparam int GAP = 354;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          start;
  logic          ready;
  logic [OW-1:0] c;
  logic          c_valid;
  logic          c_ready;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  karatsuba_serial_scheduler dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .start   (start),
    .ready   (ready),
    .c       (c),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Schoolbook carry-free product, one multiplier bit at a time
  function automatic logic [OW-1:0] gf2mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [OW-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (y[i]) r = r ^ (OW'(x) << i);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = (r << 32) | W'($urandom());
    return r;
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count cycles from the accept edge until c_valid, watching ready/busy
  task automatic wait_result(output int lat, output bit rdy_ok);
    lat    = 0;
    rdy_ok = 1'b1;
    while (!c_valid && lat < 1000) begin
      if (ready !== 1'b0 || busy !== 1'b1) rdy_ok = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output bit rdy_ok);
    a     = x;
    b     = y;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_result(lat, rdy_ok);
  endtask

  logic [W-1:0]  xa;
  logic [W-1:0]  xb;
  logic [OW-1:0] c0;
  logic [OW-1:0] exp_q[$];
  int            lat;
  bit            ok;
  int            cyc;
  int            last_acc;
  int            n_acc;
  int            n_res;
  int            gap_bad;
  bit            accepting;

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    c_ready = 1'b1;
    a       = '0;
    b       = '0;
    step();
    step();
    check("reset_c", c, '0);
    check("reset_c_valid", OW'(c_valid), '0);
    check("reset_ready", OW'(ready), OW'(1));
    check("reset_busy", OW'(busy), '0);
    rst = 1'b0;
    step();

    // Basic square of (x+1)
    run_op(W'(3), W'(3), lat, ok);
    check("basic_c", c, OW'(5));
    check("basic_latency", OW'(lat), OW'(LAT));
    check("basic_ready_low", OW'(ok), OW'(1));
    step();
    check("basic_released", OW'(c_valid), '0);
    check("basic_ready_back", OW'(ready), OW'(1));

    // Split boundary cases
    xa = (W'(1) << 116) | (W'(1) << 117);
    run_op(xa, W'(1), lat, ok);
    check("split_lo_hi", c, OW'(xa));
    step();
    xa = W'(1) << 117;
    run_op(xa, xa, lat, ok);
    check("split_hh", c, OW'(1) << 234);
    step();
    xa = W'(1) << 232;
    run_op(xa, xa, lat, ok);
    check("split_top", c, OW'(1) << 464);
    check("split_top_msb0", OW'(c[OW-1]), '0);
    check("split_top_latency", OW'(lat), OW'(LAT));
    step();

    // Backpressure: result held, start ignored while DONE
    c_ready = 1'b0;
    xa = rand_op();
    xb = rand_op();
    run_op(xa, xb, lat, ok);
    check("bp_c", c, gf2mul(xa, xb));
    c0 = c;
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      start = 1'b1;
      a     = rand_op();
      b     = rand_op();
      step();
      if (c !== c0 || c_valid !== 1'b1 || ready !== 1'b0) ok = 1'b0;
    end
    check("bp_hold_stable", OW'(ok), OW'(1));
    a       = W'(3);
    b       = W'(7);
    c_ready = 1'b1;
    step();
    check("bp_release_valid", OW'(c_valid), '0);
    check("bp_release_ready", OW'(ready), OW'(1));
    check("bp_c_kept", c, c0);
    step();
    start = 1'b0;
    check("bp_next_accept", OW'(busy), OW'(1));
    wait_result(lat, ok);
    check("bp_next_c", c, OW'(9));
    check("bp_next_latency", OW'(lat), OW'(LAT));
    step();

    // Asynchronous reset during the hi*hi pass
    a     = rand_op();
    b     = rand_op();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (150) step();
    #3 rst = 1'b1;
    #1;
    check("rst_mid_c", c, '0);
    check("rst_mid_c_valid", OW'(c_valid), '0);
    check("rst_mid_busy", OW'(busy), '0);
    check("rst_mid_ready", OW'(ready), OW'(1));
    #2 rst = 1'b0;
    step();
    run_op(W'(3), W'(5), lat, ok);
    check("rst_after_c", c, OW'(15));
    check("rst_after_latency", OW'(lat), OW'(LAT));
    step();

    // Start pulse during MUL_MID must be ignored
    xa = rand_op();
    xb = rand_op();
    a     = xa;
    b     = xb;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (260) step();
    a     = rand_op();
    b     = rand_op();
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 261;
    while (!c_valid && lat < 1000) begin
      step();
      lat++;
    end
    check("ign_c", c, gf2mul(xa, xb));
    check("ign_latency", OW'(lat), OW'(LAT));
    step();
    ok = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (c_valid !== 1'b0 || ready !== 1'b1) ok = 1'b0;
      step();
    end
    check("ign_no_second", OW'(ok), OW'(1));

    // Back-to-back random traffic with start held high
    cyc      = 0;
    last_acc = 0;
    n_acc    = 0;
    n_res    = 0;
    gap_bad  = 0;
    xa       = rand_op();
    xb       = rand_op();
    a        = xa;
    b        = xb;
    start    = 1'b1;
    c_ready  = 1'b1;
    while (n_res < 200 && cyc < 75000) begin
      accepting = (ready === 1'b1) && start;
      if (accepting) begin
        exp_q.push_back(gf2mul(xa, xb));
        if (n_acc > 0 && (cyc - last_acc) != GAP) gap_bad++;
        last_acc = cyc;
        n_acc++;
      end
      if (c_valid === 1'b1) begin
        if (exp_q.size() > 0) check("b2b_c", c, exp_q.pop_front());
        else check("b2b_unexpected_result", OW'(1), '0);
        n_res++;
      end
      step();
      cyc++;
      if (accepting) begin
        xa = rand_op();
        xb = rand_op();
        a  = xa;
        b  = xb;
        if (n_acc == 200) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_result_count", OW'(n_res), OW'(200));
    check("b2b_accept_spacing", OW'(gap_bad), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
